// File: rtl/ocmem_reader_pkg.sv
// Shared types and defaults for the on-chip memory block reader.
package ocmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } ocmem_state_t;

  localparam int unsigned OCMEM_RD_LAT     = 1;
  localparam int unsigned OCMEM_MEM_WIDTH  = 32;
  localparam int unsigned OCMEM_ADDR_WIDTH = 10;
  localparam int unsigned OCMEM_LEN_WIDTH  = 11;
  localparam int unsigned OCMEM_FIFO_DEPTH = 4;

endpackage

// File: rtl/ocmem_reader_if.sv
// Valid/ready word stream carrying memory data plus an end-of-pass marker.
interface ocmem_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/ocmem_reader_skid_fifo.sv
// Small synchronous FIFO absorbing the memory read latency under backpressure.
module ocmem_skid_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  // Storage is cleared on reset so the stream data output reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/ocmem_reader.sv
// Streams LEN consecutive memory words from BASE with full backpressure.
// Optional OCMEM_READER_LOOP_EN adds loop_i/stop_i for repeated passes.
module ocmem_reader
  import ocmem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH  = OCMEM_MEM_WIDTH,
  parameter int unsigned ADDR_WIDTH = OCMEM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = OCMEM_LEN_WIDTH,
  parameter int unsigned FIFO_DEPTH = OCMEM_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef OCMEM_READER_LOOP_EN
  input  logic                  loop_i,
  input  logic                  stop_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [MEM_WIDTH-1:0]  mem_d_o,
  input  logic [MEM_WIDTH-1:0]  mem_q_i,
  ocmem_reader_if.master        m
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ocmem_state_t          state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic                  busy;
  logic                  done;

  logic                  issue;
  logic                  drained;
  logic                  pop;
  logic                  valid;
  logic [CW-1:0]         occ;
  logic [MEM_WIDTH:0]    fifo_out;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;

`ifdef OCMEM_READER_LOOP_EN
  logic [ADDR_WIDTH-1:0] base_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic                  loop_r;
  logic                  stop_req;
  logic                  cont;
  assign cont = loop_r && loop_i && !stop_req && !stop_i;
`endif

  ocmem_skid_fifo #(
    .WIDTH (MEM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (inflight),
    .push_data ({inflight_last, mem_q_i}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign valid   = !empty;
  assign pop     = valid && m.ready;
  assign occ     = count + CW'(inflight);
  assign issue   = (state == RUN) && (remaining != '0) && (occ < CW'(FIFO_DEPTH)) && !full;
  // Look one pop ahead so done lands the cycle right after the final beat.
  assign drained = !inflight && (empty || (count == CW'(1) && pop));

  assign m.data     = fifo_out[MEM_WIDTH-1:0];
  assign m.last     = fifo_out[MEM_WIDTH];
  assign m.valid    = valid;
  assign mem_ce_o   = issue;
  assign mem_we_o   = 1'b0;
  assign mem_d_o    = '0;
  assign mem_addr_o = addr;
  assign busy_o     = busy;
  assign done_o     = done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef OCMEM_READER_LOOP_EN
      base_r        <= '0;
      len_r         <= '0;
      loop_r        <= 1'b0;
      stop_req      <= 1'b0;
`endif
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_WIDTH'(1));
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            addr      <= base_i;
            remaining <= len_i;
`ifdef OCMEM_READER_LOOP_EN
            base_r    <= base_i;
            len_r     <= len_i;
            loop_r    <= loop_i;
            stop_req  <= 1'b0;
`endif
            if (len_i == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
`ifdef OCMEM_READER_LOOP_EN
          if (stop_i) stop_req <= 1'b1;
`endif
          if (issue) begin
            if (remaining == LEN_WIDTH'(1)) begin
`ifdef OCMEM_READER_LOOP_EN
              if (cont) begin
                addr      <= base_r;
                remaining <= len_r;
              end else begin
`endif
                addr      <= addr + 1'b1;
                remaining <= '0;
                state     <= DRAIN;
`ifdef OCMEM_READER_LOOP_EN
              end
`endif
            end else begin
              addr      <= addr + 1'b1;
              remaining <= remaining - 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ocmem_reader.sv
// Self-checking bench: transaction-level model of the reader plus directed scenarios.
module tb_ocmem_reader;
  localparam int unsigned MW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy, done, ce, we;
  logic [AW-1:0] maddr;
  logic [MW-1:0] md, mq;
`ifdef OCMEM_READER_LOOP_EN
  logic          loop_in = 1'b0;
  logic          stop_in = 1'b0;
`else
  logic          loop_in;
  logic          stop_in;
  assign loop_in = 1'b0;
  assign stop_in = 1'b0;
`endif

  ocmem_reader_if #(.DATA_WIDTH(MW)) s_if ();

  ocmem_reader #(
    .MEM_WIDTH  (MW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_i     (base),
    .len_i      (len),
`ifdef OCMEM_READER_LOOP_EN
    .loop_i     (loop_in),
    .stop_i     (stop_in),
`endif
    .busy_o     (busy),
    .done_o     (done),
    .mem_ce_o   (ce),
    .mem_we_o   (we),
    .mem_addr_o (maddr),
    .mem_d_o    (md),
    .mem_q_i    (mq),
    .m          (s_if)
  );

  always #5 clk = ~clk;

  logic [MW-1:0] mem [1024];
  initial for (int k = 0; k < 1024; k++) mem[k] = k;
  always @(posedge clk) if (ce) mq <= mem[maddr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: each accepted pass expands into its address and word lists.
  logic [AW-1:0] addr_q [$];
  logic [MW:0]   exp_q [$];
  bit            active = 0, done_due = 0, loop_mode = 0, stop_seen = 0;
  bit            stall_prev = 0;
  logic [MW:0]   stall_word;
  logic [AW-1:0] p_base;
  logic [LW-1:0] p_len;
  int            outstanding = 0;
  int            cyc = 0, acc_cyc = 0, done_cyc = -1;
  int            beat_n = 0, addr_n = 0;
  logic [MW-1:0] beat_d [64];
  logic          beat_l [64];
  int            beat_c [64];
  logic [AW-1:0] addr_log [64];

  function automatic void push_pass();
    for (int i = 0; i < int'(p_len); i++) begin
      addr_q.push_back(p_base + AW'(i));
      exp_q.push_back({(i == int'(p_len) - 1), mem[p_base + AW'(i)]});
    end
  endfunction

  always @(negedge clk) begin
    bit          next_done;
    logic [MW:0] w;
    cyc++;
    if (rst) begin
      check("rst_valid", s_if.valid, 0);
      check("rst_ce", ce, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      addr_q.delete(); exp_q.delete();
      active = 0; done_due = 0; stall_prev = 0; stop_seen = 0; outstanding = 0;
    end else begin
      next_done = 0;
      check("done", done, done_due);
      check("busy", busy, active);
      check("we_zero", {we, md}, 0);
      check("outstanding_le_4", outstanding <= 4, 1);
      if (done) done_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", s_if.valid, 1);
        check("stall_word", {s_if.last, s_if.data}, stall_word);
      end
      if (s_if.valid) check("valid_has_word", exp_q.size() != 0, 1);
      if (ce) begin
        check("ce_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          check("addr", maddr, addr_q.pop_front());
          outstanding++;
        end
        if (addr_n < 64) addr_log[addr_n] = maddr;
        addr_n++;
        if (loop_mode && addr_q.size() == 0 && loop_in && !stop_seen && !stop_in) push_pass();
      end
      if (s_if.valid && s_if.ready && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("beat", {s_if.last, s_if.data}, w);
        outstanding--;
        if (beat_n < 64) begin
          beat_d[beat_n] = s_if.data; beat_l[beat_n] = s_if.last; beat_c[beat_n] = cyc;
        end
        beat_n++;
        if (exp_q.size() == 0 && addr_q.size() == 0 && active) begin
          next_done = 1; active = 0;
        end
      end
      if (active && stop_in) stop_seen = 1;
      if (start && !active && !done_due) begin
        acc_cyc = cyc;
        if (len == 0) next_done = 1;
        else begin
          active = 1; p_base = base; p_len = len; loop_mode = loop_in; stop_seen = 0;
          push_pass();
        end
      end
      stall_prev = s_if.valid && !s_if.ready;
      stall_word = {s_if.last, s_if.data};
      done_due   = next_done;
    end
  end

  task automatic clear_logs();
    beat_n = 0; addr_n = 0; done_cyc = -1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    @(posedge clk); #1;
    base = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit bp);
    int n = 0;
    while ((active || done_due) && n < 500) begin
      @(posedge clk); #1;
      if (bp) s_if.ready = (n % 4 == 0) || (n % 4 == 3);
      n++;
    end
    check("wait_idle_timeout", n < 500, 1);
    s_if.ready = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; s_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", maddr, 0);
    check("reset_data", {s_if.last, s_if.data}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic: base 5, len 4
    clear_logs();
    pulse_start(10'd5, 11'd4);
    wait_idle(0);
    check("basic_count", beat_n, 4);
    for (int i = 0; i < 4; i++) check("basic_data", beat_d[i], 5 + i);
    check("basic_last3", beat_l[3], 1);
    check("basic_last0", beat_l[0], 0);
    check("basic_first_latency", beat_c[0] - acc_cyc, 3);
    check("basic_back_to_back", beat_c[3] - beat_c[0], 3);
    check("basic_done_cycle", done_cyc - acc_cyc, 7);

    // Backpressure: base 0, len 8, ready 1,0,0,1
    clear_logs();
    pulse_start(10'd0, 11'd8);
    wait_idle(1);
    check("bp_count", beat_n, 8);
    for (int i = 0; i < 8; i++) check("bp_data", beat_d[i], i);
    check("bp_last", beat_l[7], 1);

    // Address wrap
    clear_logs();
    pulse_start(10'h3FE, 11'd4);
    wait_idle(0);
    check("wrap_addr0", addr_log[0], 10'h3FE);
    check("wrap_addr1", addr_log[1], 10'h3FF);
    check("wrap_addr2", addr_log[2], 10'h000);
    check("wrap_addr3", addr_log[3], 10'h001);
    check("wrap_data2", beat_d[2], 0);

    // Zero length
    clear_logs();
    pulse_start(10'd9, 11'd0);
    wait_idle(0);
    check("len0_done_cycle", done_cyc - acc_cyc, 1);
    check("len0_no_beats", beat_n, 0);

    // Start while running is ignored
    clear_logs();
    pulse_start(10'd0, 11'd8);
    repeat (2) @(posedge clk);
    pulse_start(10'h100, 11'd3);
    wait_idle(0);
    check("busy_start_count", beat_n, 8);
    for (int i = 0; i < 8; i++) check("busy_start_data", beat_d[i], i);

    // Reset mid-run, then a clean transfer
    clear_logs();
    pulse_start(10'd0, 11'd10);
    for (int n = 0; n < 100 && beat_n < 3; n++) @(negedge clk);
    check("midrun_progress", beat_n >= 3, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun_rst_outputs", {s_if.valid, s_if.last, s_if.data, ce, maddr, busy, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    pulse_start(10'h20, 11'd2);
    wait_idle(0);
    check("post_rst_count", beat_n, 2);
    check("post_rst_d0", beat_d[0], 32'h20);
    check("post_rst_d1", beat_d[1], 32'h21);
    check("post_rst_last", beat_l[1], 1);

`ifdef OCMEM_READER_LOOP_EN
    // Looping passes, stopped by a stop pulse
    clear_logs();
    loop_in = 1'b1;
    pulse_start(10'd0, 11'd3);
    for (int n = 0; n < 100 && beat_n < 7; n++) @(negedge clk);
    @(posedge clk); #1;
    stop_in = 1'b1;
    @(posedge clk); #1;
    stop_in = 1'b0;
    loop_in = 1'b0;
    wait_idle(0);
    for (int i = 0; i < 7; i++) begin
      check("loop_data", beat_d[i], i % 3);
      check("loop_last", beat_l[i], (i % 3) == 2);
    end
    for (int i = 0; i < 6; i++) check("loop_no_bubble", beat_c[i+1] - beat_c[i], 1);
    check("loop_whole_passes", beat_n % 3, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
